// File: rtl/lfsr_step_ctrl_if.sv
// Command and LFSR-control bundle for lfsr_step_ctrl.
// A command transfers on a rising edge where cmd_valid & cmd_ready; cmd_ready is high only while idle, so nothing is ever queued.
interface lfsr_step_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [7:0] lfsr_seed;
  logic       lfsr_load;
  logic       lfsr_step;
  logic [1:0] lfsr_mode;
  logic [4:0] steps_left;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, lfsr_seed, lfsr_load, lfsr_step, lfsr_mode, steps_left, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, lfsr_seed, lfsr_load, lfsr_step, lfsr_mode, steps_left, busy, done
  );
endinterface

// File: rtl/lfsr_step_ctrl.sv
// Command sequencer for the 8-bit LFSR: seed assembly, mode latch and prescaled step bursts.
// Optional feature: define LFSR_CTRL_ZERO_GUARD_EN to present seed 0x01 instead of 0x00 on load.
module lfsr_step_ctrl #(
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_step_ctrl_if.slave   bus,
  output logic [1:0]        dbg_state
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] OP_SEED_LO = 2'd0;
  localparam logic [1:0] OP_SEED_HI = 2'd1;
  localparam logic [1:0] OP_MODE    = 2'd2;
  localparam logic [1:0] OP_RUN     = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [1:0]    mode_q, mode_d;
  logic [4:0]    steps_q, steps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          step_now;

  assign accept   = bus.cmd_valid && (state_q == ST_IDLE);
  assign step_now = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    steps_d  = steps_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_SEED_LO: shadow_d[3:0] = bus.cmd_arg;
            OP_SEED_HI: begin
              shadow_d[7:4] = bus.cmd_arg;
              state_d       = ST_LOAD;
            end
            OP_MODE:    mode_d = bus.cmd_arg[1:0];
            OP_RUN: begin
              // An argument of 0 encodes the full 16-step burst.
              steps_d = (bus.cmd_arg == 4'd0) ? 5'd16 : {1'b0, bus.cmd_arg};
              cnt_d   = '0;
              state_d = ST_RUN;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_RUN: begin
        if (step_now) begin
          cnt_d   = '0;
          steps_d = steps_q - 5'd1;
          if (steps_q == 5'd1) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= 8'h00;
      mode_q   <= 2'd0;
      steps_q  <= 5'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      steps_q  <= steps_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.lfsr_load  = (state_q == ST_LOAD);
  assign bus.lfsr_step  = step_now;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.lfsr_mode  = mode_q;
  assign bus.steps_left = steps_q;
  assign dbg_state      = state_q;

`ifdef LFSR_CTRL_ZERO_GUARD_EN
  // An all-zero seed would lock the LFSR, so substitute 0x01 while loading.
  assign bus.lfsr_seed = ((state_q == ST_LOAD) && (shadow_q == 8'h00)) ? 8'h01 : shadow_q;
`else
  assign bus.lfsr_seed = shadow_q;
`endif

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Bench for lfsr_step_ctrl: PRESCALE=1 and PRESCALE=4 instances share one command stream,
// each checked every cycle against a timeline model of its accepted commands.
module tb_lfsr_step_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic       drv_valid;
  logic [1:0] drv_op;
  logic [3:0] drv_arg;

  always #5 clk = ~clk;

  lfsr_step_ctrl_if if_p1();
  lfsr_step_ctrl_if if_p4();

  assign if_p1.cmd_valid = drv_valid;
  assign if_p1.cmd_op    = drv_op;
  assign if_p1.cmd_arg   = drv_arg;
  assign if_p4.cmd_valid = drv_valid;
  assign if_p4.cmd_op    = drv_op;
  assign if_p4.cmd_arg   = drv_arg;

  logic [1:0] dbg_p1, dbg_p4;

  lfsr_step_ctrl #(.PRESCALE(1)) u_dut_p1 (.clk(clk), .rst(rst), .bus(if_p1), .dbg_state(dbg_p1));
  lfsr_step_ctrl #(.PRESCALE(4)) u_dut_p4 (.clk(clk), .rst(rst), .bus(if_p4), .dbg_state(dbg_p4));

  logic       obs_ready [2];
  logic       obs_busy  [2];
  logic       obs_load  [2];
  logic       obs_step  [2];
  logic       obs_done  [2];
  logic [1:0] obs_mode  [2];
  logic [4:0] obs_left  [2];
  logic [7:0] obs_seed  [2];

  assign obs_ready[0] = if_p1.cmd_ready;  assign obs_ready[1] = if_p4.cmd_ready;
  assign obs_busy[0]  = if_p1.busy;       assign obs_busy[1]  = if_p4.busy;
  assign obs_load[0]  = if_p1.lfsr_load;  assign obs_load[1]  = if_p4.lfsr_load;
  assign obs_step[0]  = if_p1.lfsr_step;  assign obs_step[1]  = if_p4.lfsr_step;
  assign obs_done[0]  = if_p1.done;       assign obs_done[1]  = if_p4.done;
  assign obs_mode[0]  = if_p1.lfsr_mode;  assign obs_mode[1]  = if_p4.lfsr_mode;
  assign obs_left[0]  = if_p1.steps_left; assign obs_left[1]  = if_p4.steps_left;
  assign obs_seed[0]  = if_p1.lfsr_seed;  assign obs_seed[1]  = if_p4.lfsr_seed;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pre(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference model: edge index t, and per instance the accepted commands as a timeline.
  // After edge t the outputs of "cycle t" are visible; a run accepted at edge k with N steps
  // pulses step at t = k + i*P - 1, done at t = k + N*P, and is ready again at k + N*P + 1.
  int         t = 0;
  int         rst_t = -1;
  bit         chk_en = 1'b0;
  int         run_k  [2];
  int         run_n  [2];
  int         free_t [2];
  int         load_t [2];
  logic [7:0] shadow [2];
  logic [1:0] mode   [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  function automatic logic [7:0] load_value(input logic [7:0] s);
`ifdef LFSR_CTRL_ZERO_GUARD_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  always @(posedge clk) begin
    t = t + 1;
    if (rst) begin
      chk_en = 1'b1;
      rst_t  = t;
      for (int d = 0; d < 2; d++) begin
        shadow[d] = 8'h00;
        mode[d]   = 2'd0;
        run_k[d]  = t;
        run_n[d]  = 0;
        free_t[d] = t;
        load_t[d] = -1;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else if (drv_valid) begin
      for (int d = 0; d < 2; d++) begin
        if (t - 1 >= free_t[d]) begin
          case (drv_op)
            2'd0: shadow[d][3:0] = drv_arg;
            2'd1: begin
              shadow[d][7:4] = drv_arg;
              load_t[d] = t;
              free_t[d] = t + 1;
              if (d == 0) exp_q0.push_back(load_value(shadow[d]));
              else        exp_q1.push_back(load_value(shadow[d]));
            end
            2'd2: mode[d] = drv_arg[1:0];
            default: begin
              run_k[d]  = t;
              run_n[d]  = (drv_arg == 4'd0) ? 16 : int'(drv_arg);
              free_t[d] = t + run_n[d] * pre(d) + 1;
            end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int p, rel, issued, nth;
        bit e_ready, e_step, e_done, e_load;
        logic [7:0] e_seed;
        string sfx;
        p       = pre(d);
        sfx     = $sformatf("[P=%0d]", p);
        rel     = t - run_k[d];
        issued  = rel / p;
        if (issued > run_n[d]) issued = run_n[d];
        nth     = (rel + 1) / p;
        e_step  = (run_n[d] > 0) && ((rel + 1) % p == 0) && (nth >= 1) && (nth <= run_n[d]);
        e_done  = (run_n[d] > 0) && (rel == run_n[d] * p);
        e_ready = (t >= free_t[d]);
        e_load  = (t == load_t[d]);
        check_eq({"cmd_ready", sfx},  32'(obs_ready[d]), 32'(e_ready));
        check_eq({"busy", sfx},       32'(obs_busy[d]),  32'(!e_ready));
        check_eq({"lfsr_load", sfx},  32'(obs_load[d]),  32'(e_load));
        check_eq({"lfsr_step", sfx},  32'(obs_step[d]),  32'(e_step));
        check_eq({"done", sfx},       32'(obs_done[d]),  32'(e_done));
        check_eq({"lfsr_mode", sfx},  32'(obs_mode[d]),  32'(mode[d]));
        check_eq({"steps_left", sfx}, 32'(obs_left[d]),  32'(run_n[d] - issued));
        if (t == rst_t) check_eq({"reset_seed", sfx}, 32'(obs_seed[d]), 32'h0);
        if (obs_load[d]) begin
          if (d == 0 && exp_q0.size() > 0)      e_seed = exp_q0.pop_front();
          else if (d == 1 && exp_q1.size() > 0) e_seed = exp_q1.pop_front();
          else e_seed = ~obs_seed[d];
          check_eq({"lfsr_seed", sfx}, 32'(obs_seed[d]), 32'(e_seed));
        end
      end
    end
  end

  task automatic wait_both_ready();
    int n;
    n = 0;
    while (!((t >= free_t[0]) && (t >= free_t[1])) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_eq("ready_timeout", 32'(n), 32'd0);
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] arg);
    wait_both_ready();
    drv_valid = 1'b1;
    drv_op    = op;
    drv_arg   = arg;
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with a RUN command pending.
    rst       = 1'b1;
    drv_valid = 1'b1;
    drv_op    = 2'd3;
    drv_arg   = 4'd5;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    drv_valid = 1'b0;
    @(negedge clk);

    send(2'd0, 4'h5);
    send(2'd1, 4'hA);
    send(2'd2, 4'h2);
    send(2'd3, 4'h3);

    // Full-length run with a SEED_HI held on the bus while busy.
    wait_both_ready();
    drv_valid = 1'b1;
    drv_op    = 2'd3;
    drv_arg   = 4'd0;
    @(negedge clk);
    drv_op    = 2'd1;
    drv_arg   = 4'h3;
    repeat (12) @(negedge clk);
    drv_valid = 1'b0;

    send(2'd0, 4'h0);
    send(2'd1, 4'h0);

    // Reset just after the second step of the PRESCALE=4 instance.
    send(2'd2, 4'h3);
    send(2'd3, 4'd8);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      drv_valid = 1'($urandom_range(0, 1));
      drv_op    = 2'($urandom_range(0, 3));
      drv_arg   = 4'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst       = 1'b0;
    drv_valid = 1'b0;
    wait_both_ready();
    repeat (3) @(negedge clk);

    check_eq("load_q_empty[P=1]", 32'(exp_q0.size()), 32'd0);
    check_eq("load_q_empty[P=4]", 32'(exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_step_ctrl.md
# lfsr_step_ctrl

Command-driven sequencer for the 8-bit greenstyle LFSR datapath. It assembles an 8-bit seed from two 4-bit nibbles, latches the tap/mode selection, and issues a programmed burst of single-cycle step pulses at a prescaled rate. Commands arrive over a 4-bit-argument valid/ready port, sized for the pin-limited tile input bus. The block sits between the tile I/O decode and the LFSR core and owns its load, step and mode controls.

## Interface
- `PRESCALE`, default 1: cycles per step pulse during a run; legal range 1..256.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_op`  in  2  0 = SEED_LO, 1 = SEED_HI, 2 = MODE, 3 = RUN.
- `cmd_arg`  in  4  command argument.
- `lfsr_seed`  out  8  seed presented to the LFSR; qualified by `lfsr_load`.
- `lfsr_load`  out  1  one-cycle pulse: LFSR loads `lfsr_seed`.
- `lfsr_step`  out  1  one-cycle pulse: LFSR advances one state.
- `lfsr_mode`  out  2  registered tap/mode select.
- `steps_left`  out  5  remaining steps in the current run (0..16).
- `busy`  out  1  high in LOAD, RUN and DONE.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, LOAD, RUN, DONE. A command is accepted on the rising edge where `cmd_valid & cmd_ready`.
- **SEED_LO** (0): `seed_shadow[3:0] <= cmd_arg`. State stays IDLE.
- **SEED_HI** (1): `seed_shadow[7:4] <= cmd_arg`, then IDLE→LOAD.
  - In LOAD: `lfsr_load = 1` and `lfsr_seed =` the full shadow, including the nibble just written.
  - LOAD→IDLE unconditionally after one cycle.
- **MODE** (2): `lfsr_mode <= cmd_arg[1:0]`; `cmd_arg[3:2]` is ignored. State stays IDLE.
- **RUN** (3): `steps_left <= (cmd_arg == 0) ? 16 : cmd_arg`, prescale counter cleared to 0, IDLE→RUN.
- In RUN:
  - The prescale counter increments each cycle.
  - When the counter equals `PRESCALE-1`: assert `lfsr_step`, decrement `steps_left`, clear the counter.
  - When the step that takes `steps_left` to 0 is issued, go RUN→DONE.
- DONE: `done = 1` for exactly one cycle, then DONE→IDLE.
- Commands are never queued. While `cmd_ready = 0`, `cmd_valid` is ignored and no shadow, mode or count state changes.
- `lfsr_mode` and `seed_shadow` persist across runs until rewritten or reset.
- Prescale counter width is `$clog2(PRESCALE)`, minimum 1 bit. With `PRESCALE = 1` the counter is always 0.

## Timing
- Reset values: state IDLE, `cmd_ready = 1`, `lfsr_seed = 0`, `lfsr_load = 0`, `lfsr_step = 0`, `lfsr_mode = 0`, `steps_left = 0`, `busy = 0`, `done = 0`. `seed_shadow` is also 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `cmd_*` to any output.
- SEED_HI accepted at edge k:
  - `lfsr_load` is high in the cycle between edges k and k+1.
  - `cmd_ready` is low in that same cycle and high again after edge k+1.
- RUN accepted at edge k with N steps (N = 1..16):
  - Step pulse i (1..N) is high in cycle k + i·PRESCALE. Cycle j means the cycle following edge k+j−1.
  - `done` is high in cycle k + N·PRESCALE + 1.
  - `cmd_ready` returns high in the following cycle.
- `busy = ~cmd_ready` at all times.
- Reset mid-operation: `rst` sampled high at an edge forces reset values in the next cycle. No further `lfsr_step`, `lfsr_load` or `done` pulse appears. A run is not resumed.
- `rst` has priority over a simultaneous command accept.

## Configuration
- `LFSR_CTRL_ZERO_GUARD_EN` defined:
  - In LOAD, if `seed_shadow == 8'h00`, then `lfsr_seed = 8'h01`. This prevents LFSR lock-up.
  - `seed_shadow` itself is unchanged.
- `LFSR_CTRL_ZERO_GUARD_EN` undefined: `lfsr_seed` always equals `seed_shadow`, including 0.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `cmd_valid = 1`, `cmd_op = 3` → all outputs at reset values, no `lfsr_step`.
- **Seed load:** SEED_LO arg 5, then SEED_HI arg A → exactly one `lfsr_load` cycle with `lfsr_seed = 0xA5`, one cycle after the SEED_HI accept. `cmd_ready` is low only in that cycle.
- **Prescaled run:** MODE arg 2, then RUN arg 3 with `PRESCALE = 1` → `lfsr_mode = 2`; step pulses in 3 consecutive cycles; `steps_left` goes 3→2→1→0; `done` the next cycle. With `PRESCALE = 4` → steps at cycles k+4, k+8, k+12 and `done` at k+13.
- **Full-length run with ignored command:** RUN arg 0 → 16 step pulses. `cmd_valid` with SEED_HI held high during the run is ignored: no `lfsr_load`, shadow unchanged.
- **Zero seed:** SEED_LO 0, SEED_HI 0 → `lfsr_seed = 0x01` with `LFSR_CTRL_ZERO_GUARD_EN` defined; `0x00` without it.
- **Reset mid-run:** assert `rst` for 1 cycle after the 2nd step of RUN arg 8 → no further steps, no `done`, `cmd_ready = 1`, `lfsr_mode = 0`.
